jmisc_timer_intc: RTL and testbench



---
 rtl/jmisc_timer_intc_if.sv | 13 +
 rtl/jmisc_timer_intc.sv | 145 ++++++++++++++
 tb/tb_jmisc_timer_intc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/jmisc_timer_intc_if.sv
// 16-bit internal register bus between the CPU-side decoder and the misc timer/interrupt block.
// The master drives address, strobes and write data; the slave returns read data and its bus-drive enable.
interface jmisc_timer_intc_if;
   logic [3:0]  addr;
   logic        wr;
   logic        rd;
   logic [15:0] din;
   logic [15:0] dout;
   logic        dr_oe;

   modport master (output addr, wr, rd, din, input dout, dr_oe);
   modport slave  (input addr, wr, rd, din, output dout, dr_oe);
endinterface

// File: rtl/jmisc_timer_intc.sv
// Jaguar misc block: NTIMER prescaler/divider timers plus an edge/level interrupt controller.
// Writes land next cycle, reads are combinational, ticks and irq are registered; no backpressure.
module jmisc_timer_intc #(
   parameter int              NTIMER   = 2,
   parameter int              CNT_W    = 16,
   parameter int              NEXT     = 4,
   parameter logic [NEXT-1:0] EXT_EDGE = NEXT'(4'b0001)
) (
   input  logic               clk,
   input  logic               reset,
   jmisc_timer_intc_if.slave  bus,
   input  logic [NEXT-1:0]    ext_int,
   output logic               irq,
   output logic [NTIMER-1:0]  pre_tick,
   output logic [NTIMER-1:0]  tmr_tick
);
   localparam int         NI       = NEXT + NTIMER;
   localparam logic [3:0] A_INTEN  = 4'd0;
   localparam logic [3:0] A_INTACK = 4'd1;
   localparam logic [3:0] A_CTRL   = 4'd2;

   logic [NI-1:0]     enable;
   logic [NI-1:0]     pending;
   logic [NI-1:0]     src_ev;
   logic [NI-1:0]     ack;
   logic [NEXT-1:0]   ext_q;
   logic [NTIMER-1:0] oneshot;
   logic [NTIMER-1:0] armed;
   logic [NTIMER-1:0] pre_wr;
   logic [NTIMER-1:0] div_wr;
   logic [CNT_W-1:0]  pre_rld [NTIMER];
   logic [CNT_W-1:0]  pre_cnt [NTIMER];
   logic [CNT_W-1:0]  div_rld [NTIMER];
   logic [CNT_W-1:0]  div_cnt [NTIMER];
   logic [CNT_W-1:0]  wr_val;
   logic [15:0]       rdata;
   logic              rvalid;
   logic              unused_din;

   assign wr_val     = bus.din[CNT_W-1:0];
   assign unused_din = ^bus.din;

   // Timer events come from the registered tick outputs, so they pend one cycle after the pulse.
   assign src_ev = {tmr_tick, (ext_int & ~ext_q & EXT_EDGE) | (ext_int & ~EXT_EDGE)};
   assign ack    = (bus.wr && bus.addr == A_INTACK) ? bus.din[NI-1:0] : '0;

   always_comb begin
      pre_wr = '0;
      div_wr = '0;
      for (int k = 0; k < NTIMER; k++) begin
         pre_wr[k] = bus.wr && (bus.addr == 4'(4 + 2*k));
         div_wr[k] = bus.wr && (bus.addr == 4'(5 + 2*k));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable   <= '0;
         pending  <= '0;
         ext_q    <= '0;
         irq      <= 1'b0;
         oneshot  <= '0;
         armed    <= '0;
         pre_tick <= '0;
         tmr_tick <= '0;
         for (int k = 0; k < NTIMER; k++) begin
            pre_rld[k] <= '0;
            pre_cnt[k] <= '0;
            div_rld[k] <= '0;
            div_cnt[k] <= '0;
         end
      end else begin
         ext_q   <= ext_int;
         pending <= (pending & ~ack) | (src_ev & enable);
         irq     <= |pending;
         if (bus.wr && bus.addr == A_INTEN) enable  <= bus.din[NI-1:0];
         if (bus.wr && bus.addr == A_CTRL)  oneshot <= bus.din[NTIMER-1:0];
         for (int k = 0; k < NTIMER; k++) begin
            pre_tick[k] <= 1'b0;
            tmr_tick[k] <= 1'b0;
            // A register write to the channel takes priority over any expiry that cycle.
            if (pre_wr[k]) begin
               pre_rld[k] <= wr_val;
               pre_cnt[k] <= wr_val;
            end else if (div_wr[k]) begin
               div_rld[k] <= wr_val;
               div_cnt[k] <= wr_val;
               armed[k]   <= 1'b1;
            end else if (armed[k] && pre_rld[k] != '0) begin
               if (pre_cnt[k] != '0) begin
                  pre_cnt[k] <= pre_cnt[k] - CNT_W'(1);
               end else begin
                  pre_tick[k] <= 1'b1;
                  if (div_cnt[k] != '0) begin
                     div_cnt[k] <= div_cnt[k] - CNT_W'(1);
                     pre_cnt[k] <= pre_rld[k];
                  end else begin
                     tmr_tick[k] <= 1'b1;
                     if (oneshot[k]) begin
                        armed[k] <= 1'b0;
                     end else begin
                        div_cnt[k] <= div_rld[k];
                        pre_cnt[k] <= pre_rld[k];
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      rdata  = '0;
      rvalid = 1'b0;
      case (bus.addr)
         A_INTEN: begin
            rvalid          = 1'b1;
            rdata[NI-1:0]   = pending;
         end
         A_INTACK: begin
            rvalid          = 1'b1;
            rdata[NI-1:0]   = src_ev;
         end
         A_CTRL: begin
            rvalid              = 1'b1;
            rdata[NTIMER-1:0]   = oneshot;
            rdata[8 +: NTIMER]  = armed;
         end
         default: begin
            for (int k = 0; k < NTIMER; k++) begin
               if (bus.addr == 4'(4 + 2*k)) begin
                  rvalid             = 1'b1;
                  rdata[CNT_W-1:0]   = pre_cnt[k];
               end else if (bus.addr == 4'(5 + 2*k)) begin
                  rvalid             = 1'b1;
                  rdata[CNT_W-1:0]   = div_cnt[k];
               end
            end
         end
      endcase
   end

   assign bus.dr_oe = bus.rd & rvalid;
   assign bus.dout  = bus.dr_oe ? rdata : '0;
endmodule

// File: tb/tb_jmisc_timer_intc.sv
// Directed bench for jmisc_timer_intc: register table plus hand sequences for timing corner cases.
module tb_jmisc_timer_intc;
   localparam int NTIMER = 2;
   localparam int CNT_W  = 8;
   localparam int NEXT   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NEXT-1:0]   ext_int;
   logic              irq;
   logic [NTIMER-1:0] pre_tick;
   logic [NTIMER-1:0] tmr_tick;
   int                checks   = 0;
   int                failures = 0;

   jmisc_timer_intc_if bus_if ();

   jmisc_timer_intc #(
      .NTIMER   (NTIMER),
      .CNT_W    (CNT_W),
      .NEXT     (NEXT),
      .EXT_EDGE (4'b0001)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .ext_int  (ext_int),
      .irq      (irq),
      .pre_tick (pre_tick),
      .tmr_tick (tmr_tick)
   );

   always #50 clk = ~clk;

   typedef struct {
      logic        do_wr;
      logic [3:0]  waddr;
      logic [15:0] wdata;
      logic [3:0]  raddr;
      logic        exp_oe;
      logic [15:0] exp_dat;
   } vec_t;

   vec_t       vecs [11];
   logic [3:0] all_addr [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; the write lands on the next rising edge.
   task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
      bus_if.addr = a;
      bus_if.din  = d;
      bus_if.wr   = 1'b1;
      @(negedge clk);
      bus_if.wr   = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic exp_oe, input logic [15:0] exp);
      bus_if.addr = a;
      bus_if.rd   = 1'b1;
      #1;
      chk({name, "_oe"}, 32'(bus_if.dr_oe), 32'(exp_oe));
      chk(name, 32'(bus_if.dout), 32'(exp));
      bus_if.rd   = 1'b0;
   endtask

   initial begin
      logic e_pre;
      logic e_tmr;

      bus_if.addr = '0;
      bus_if.wr   = 1'b0;
      bus_if.rd   = 1'b0;
      bus_if.din  = '0;
      ext_int     = '0;
      reset       = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) rd_chk($sformatf("rst_rd%0d", all_addr[i]), all_addr[i], 1'b1, 16'h0000);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_ticks", 32'({pre_tick, tmr_tick}), 32'd0);

      vecs[0]  = '{1'b1, 4'd4, 16'hFFFF, 4'd4, 1'b1, 16'h00FF};
      vecs[1]  = '{1'b1, 4'd4, 16'h1234, 4'd4, 1'b1, 16'h0034};
      vecs[2]  = '{1'b1, 4'd6, 16'h00A5, 4'd6, 1'b1, 16'h00A5};
      vecs[3]  = '{1'b1, 4'd2, 16'hFFFF, 4'd2, 1'b1, 16'h0003};
      vecs[4]  = '{1'b1, 4'd3, 16'hFFFF, 4'd2, 1'b1, 16'h0003};
      vecs[5]  = '{1'b1, 4'd2, 16'h0000, 4'd2, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 4'd0, 16'h0000, 4'd3, 1'b0, 16'h0000};
      vecs[7]  = '{1'b0, 4'd0, 16'h0000, 4'd8, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 1'b1, 16'h0000};
      vecs[9]  = '{1'b1, 4'd0, 16'h0000, 4'd1, 1'b1, 16'h0000};
      vecs[10] = '{1'b0, 4'd0, 16'h0000, 4'd5, 1'b1, 16'h0000};
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_wr) wr_reg(vecs[i].waddr, vecs[i].wdata);
         rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_oe, vecs[i].exp_dat);
      end

      // Periodic timer 0: prescale 4 cycles, divide by 5 -> tick every 20 cycles.
      @(negedge clk);
      wr_reg(4'd4, 16'd3);
      wr_reg(4'd0, 16'h0010);
      wr_reg(4'd5, 16'd4);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         e_pre = ((i % 4) == 0);
         e_tmr = ((i % 20) == 0);
         chk($sformatf("pre_tick0_c%0d", i), 32'(pre_tick[0]), 32'(e_pre));
         chk($sformatf("tmr_tick0_c%0d", i), 32'(tmr_tick[0]), 32'(e_tmr));
         chk($sformatf("t1_quiet_c%0d", i), 32'({pre_tick[1], tmr_tick[1]}), 32'd0);
         if (i == 20) rd_chk("pend_before_tick", 4'd0, 1'b1, 16'h0000);
         if (i == 21) begin
            rd_chk("pend_after_tick", 4'd0, 1'b1, 16'h0010);
            chk("irq_c21", 32'(irq), 32'd0);
         end
         if (i == 22) chk("irq_c22", 32'(irq), 32'd1);
      end

      // Ack in the same cycle as the tick: the new event wins.
      wr_reg(4'd1, 16'h0010);
      rd_chk("ack_race_pend", 4'd0, 1'b1, 16'h0010);
      wr_reg(4'd1, 16'h0010);
      rd_chk("ack_clear_pend", 4'd0, 1'b1, 16'h0000);
      chk("irq_hold", 32'(irq), 32'd1);
      @(negedge clk);
      chk("irq_drop", 32'(irq), 32'd0);

      // PRE=0 written on the very cycle the prescaler would expire.
      wr_reg(4'd4, 16'd0);
      chk("pre_write_wins", 32'(pre_tick[0]), 32'd0);
      rd_chk("pre_frozen", 4'd4, 1'b1, 16'h0000);
      rd_chk("div_held", 4'd5, 1'b1, 16'h0004);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk($sformatf("frozen_quiet_c%0d", i), 32'({pre_tick, tmr_tick}), 32'd0);
      end
      rd_chk("pre_still_frozen", 4'd4, 1'b1, 16'h0000);
      rd_chk("div_still_held", 4'd5, 1'b1, 16'h0004);
      rd_chk("ctrl_armed_kept", 4'd2, 1'b1, 16'h0100);
      wr_reg(4'd4, 16'hFFFF);
      rd_chk("pre_trunc", 4'd4, 1'b1, 16'h00FF);
      wr_reg(4'd4, 16'd0);

      // One-shot timer 1: (1+1)*(2+1) = 6 cycles, then disarms.
      wr_reg(4'd2, 16'h0002);
      wr_reg(4'd6, 16'd1);
      wr_reg(4'd0, 16'h0020);
      wr_reg(4'd7, 16'd2);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         e_pre = (i == 2) || (i == 4) || (i == 6);
         e_tmr = (i == 6);
         chk($sformatf("os_pre_c%0d", i), 32'(pre_tick[1]), 32'(e_pre));
         chk($sformatf("os_tmr_c%0d", i), 32'(tmr_tick[1]), 32'(e_tmr));
         chk($sformatf("os_t0_quiet_c%0d", i), 32'({pre_tick[0], tmr_tick[0]}), 32'd0);
      end
      rd_chk("os_disarmed", 4'd2, 1'b1, 16'h0102);
      rd_chk("os_pend", 4'd0, 1'b1, 16'h0020);
      wr_reg(4'd6, 16'd1);
      wr_reg(4'd7, 16'd2);
      rd_chk("os_rearmed", 4'd2, 1'b1, 16'h0302);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         e_tmr = (i == 6);
         chk($sformatf("os2_tmr_c%0d", i), 32'(tmr_tick[1]), 32'(e_tmr));
      end
      rd_chk("os_disarmed2", 4'd2, 1'b1, 16'h0102);
      wr_reg(4'd1, 16'h0020);
      rd_chk("os_acked", 4'd0, 1'b1, 16'h0000);

      // Edge source 0 held high 10 cycles, acked once: must not re-pend.
      wr_reg(4'd0, 16'h0003);
      ext_int = 4'b0001;
      rd_chk("edge_raw", 4'd1, 1'b1, 16'h0001);
      @(negedge clk);
      rd_chk("edge_pend", 4'd0, 1'b1, 16'h0001);
      rd_chk("edge_raw_gone", 4'd1, 1'b1, 16'h0000);
      repeat (2) @(negedge clk);
      wr_reg(4'd1, 16'h0001);
      rd_chk("edge_acked", 4'd0, 1'b1, 16'h0000);
      repeat (6) @(negedge clk);
      rd_chk("edge_no_repend", 4'd0, 1'b1, 16'h0000);
      ext_int = 4'b0000;

      // Level source 1: ack while high is overridden by the live event.
      ext_int = 4'b0010;
      rd_chk("level_raw", 4'd1, 1'b1, 16'h0002);
      @(negedge clk);
      rd_chk("level_pend", 4'd0, 1'b1, 16'h0002);
      wr_reg(4'd1, 16'h0002);
      rd_chk("level_repend", 4'd0, 1'b1, 16'h0002);
      ext_int = 4'b0000;
      @(negedge clk);
      wr_reg(4'd0, 16'h0000);
      rd_chk("disable_keeps_pend", 4'd0, 1'b1, 16'h0002);
      wr_reg(4'd1, 16'h0002);
      rd_chk("level_acked", 4'd0, 1'b1, 16'h0000);

      // Reset while timer 0 runs with irq asserted; a concurrent CTRL write must be dropped.
      wr_reg(4'd4, 16'd3);
      wr_reg(4'd0, 16'h0010);
      wr_reg(4'd5, 16'd0);
      repeat (8) @(negedge clk);
      chk("irq_before_reset", 32'(irq), 32'd1);
      bus_if.addr = 4'd2;
      bus_if.din  = 16'hFFFF;
      bus_if.wr   = 1'b1;
      reset       = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      bus_if.wr   = 1'b0;
      chk("mid_rst_irq", 32'(irq), 32'd0);
      chk("mid_rst_ticks", 32'({pre_tick, tmr_tick}), 32'd0);
      for (int i = 0; i < 7; i++) rd_chk($sformatf("mid_rst_rd%0d", all_addr[i]), all_addr[i], 1'b1, 16'h0000);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_quiet_c%0d", i), 32'({irq, pre_tick, tmr_tick}), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
